// File: rtl/ysyx_210238_axi_pkg.sv
// Shared definitions for the two-requester AXI read arbiter.
package ysyx_210238_axi_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // AR IDs per requester.
  localparam logic [3:0] ID_IF  = 4'd0;
  localparam logic [3:0] ID_LSU = 4'd1;

  // Encoding of the last_grant bit.
  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // AXI RRESP codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_210238_axi_rd_arb_if.sv
// Bundle of requester-side and AXI-side signals around the read arbiter.
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; valid and payload are held by the
// source until that edge, and ready may depend combinationally on valid.
interface ysyx_210238_axi_rd_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  // Instruction fetch requester.
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic [LEN_W-1:0]  if_req_len;
  logic [2:0]        if_req_size;
  logic              if_rsp_valid;
  logic              if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_data;
  logic [1:0]        if_rsp_resp;
  logic              if_rsp_last;

  // Load/store unit requester.
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [LEN_W-1:0]  lsu_req_len;
  logic [2:0]        lsu_req_size;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DATA_W-1:0] lsu_rsp_data;
  logic [1:0]        lsu_rsp_resp;
  logic              lsu_rsp_last;

  // AXI read address channel.
  logic              m_ar_valid;
  logic              m_ar_ready;
  logic [ADDR_W-1:0] m_ar_addr;
  logic [LEN_W-1:0]  m_ar_len;
  logic [2:0]        m_ar_size;
  logic [3:0]        m_ar_id;

  // AXI read data channel.
  logic              m_r_valid;
  logic              m_r_ready;
  logic [DATA_W-1:0] m_r_data;
  logic [1:0]        m_r_resp;
  logic              m_r_last;

  // Arbiter view: serves the requesters, masters the AXI read channel.
  modport master (
    input  if_req_valid, if_req_addr, if_req_len, if_req_size, if_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    input  lsu_req_valid, lsu_req_addr, lsu_req_len, lsu_req_size, lsu_rsp_ready,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_resp, lsu_rsp_last,
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_id,
    input  m_ar_ready,
    input  m_r_valid, m_r_data, m_r_resp, m_r_last,
    output m_r_ready
  );

  // Environment view: requesters plus the AXI bridge.
  modport slave (
    output if_req_valid, if_req_addr, if_req_len, if_req_size, if_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    output lsu_req_valid, lsu_req_addr, lsu_req_len, lsu_req_size, lsu_rsp_ready,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_resp, lsu_rsp_last,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_id,
    output m_ar_ready,
    output m_r_valid, m_r_data, m_r_resp, m_r_last,
    input  m_r_ready
  );

endinterface

// File: rtl/ysyx_210238_rr_arb2.sv
// Two-way round-robin picker. req[0] is IF, req[1] is LSU. On a tie the
// requester not granted last wins; last_grant records the most recent winner
// and therefore also names the requester owning the current transaction.
module ysyx_210238_rr_arb2
  import ysyx_210238_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic last_grant_q, last_grant_d;

  // One-hot winner selection.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == GNT_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner whenever a grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (update) last_grant_d = grant[1] ? GNT_LSU : GNT_IF;
  end

  // last_grant starts at LSU so IF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GNT_LSU;
    else        last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/ysyx_210238_axi_rd_arb.sv
// Shares one AXI read channel between IF and LSU: one transaction at a time,
// round-robin on ties, AR payload registered, R channel passed straight
// through to whichever requester owns the transaction.
module ysyx_210238_axi_rd_arb
  import ysyx_210238_axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_210238_axi_rd_arb_if.master    bus,
  output logic                        busy,
  output state_e                      state_o
);

  state_e            state_q, state_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        id_q, id_d;
  logic              busy_q, busy_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       accept;
  logic       owner_lsu;
  logic       in_idle;
  logic       in_data;
  logic       sel_if;
  logic       sel_lsu;
  logic       r_fire;

  // Requests are only offered to the picker in IDLE and never during reset,
  // so ready stays low outside IDLE and while rst_n is asserted.
  assign in_idle = (state_q == ST_IDLE) && rst_n;
  assign req     = in_idle ? {bus.lsu_req_valid, bus.if_req_valid} : 2'b00;
  assign accept  = |grant;

  ysyx_210238_rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .update     (accept),
    .grant      (grant),
    .last_grant (owner_lsu)
  );

  assign bus.if_req_ready  = grant[0];
  assign bus.lsu_req_ready = grant[1];

  // R routing: only the owner sees beats and drives m_r_ready.
  assign in_data = (state_q == ST_DATA);
  assign sel_if  = in_data && (owner_lsu == GNT_IF);
  assign sel_lsu = in_data && (owner_lsu == GNT_LSU);
  assign r_fire  = bus.m_r_valid && bus.m_r_ready;

  assign bus.m_r_ready = (sel_if && bus.if_rsp_ready) || (sel_lsu && bus.lsu_rsp_ready);

  assign bus.if_rsp_valid  = sel_if && bus.m_r_valid;
  assign bus.if_rsp_data   = sel_if ? bus.m_r_data : {DATA_W{1'b0}};
  assign bus.if_rsp_resp   = sel_if ? bus.m_r_resp : 2'b00;
  assign bus.if_rsp_last   = sel_if && bus.m_r_last;

  assign bus.lsu_rsp_valid = sel_lsu && bus.m_r_valid;
  assign bus.lsu_rsp_data  = sel_lsu ? bus.m_r_data : {DATA_W{1'b0}};
  assign bus.lsu_rsp_resp  = sel_lsu ? bus.m_r_resp : 2'b00;
  assign bus.lsu_rsp_last  = sel_lsu && bus.m_r_last;

  // Next-state logic: accept in IDLE, issue AR in ADDR, drain beats in DATA.
  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    id_d       = id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_ADDR;
          ar_valid_d = 1'b1;
          if (grant[1]) begin
            addr_d = bus.lsu_req_addr;
            len_d  = bus.lsu_req_len;
            size_d = bus.lsu_req_size;
            id_d   = ID_LSU;
          end else begin
            addr_d = bus.if_req_addr;
            len_d  = bus.if_req_len;
            size_d = bus.if_req_size;
            id_d   = ID_IF;
          end
        end
      end
      ST_ADDR: begin
        if (bus.m_ar_ready) begin
          state_d    = ST_DATA;
          ar_valid_d = 1'b0;
        end
      end
      ST_DATA: begin
        // RRESP does not matter here: the burst always ends on last.
        if (r_fire && bus.m_r_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, AR payload and busy flag; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ar_valid_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      id_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m_ar_valid = ar_valid_q;
  assign bus.m_ar_addr  = addr_q;
  assign bus.m_ar_len   = len_q;
  assign bus.m_ar_size  = size_q;
  assign bus.m_ar_id    = id_q;
  assign busy           = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ysyx_210238_axi_rd_arb.sv
// Bench for the two-requester AXI read arbiter: directed scenarios, expected
// AR and R traffic queued at issue time and checked by negedge monitors.
module tb_ysyx_210238_axi_rd_arb;
  import ysyx_210238_axi_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_e state_o;

  int n_checks = 0;
  int n_errors = 0;
  int beat_seq = 0;
  int w_if;
  int w_lsu;
  int w_tmp;

  // {id, addr, len, size} and {data, resp, last}
  logic [78:0] exp_ar_q[$];
  logic [66:0] exp_if_q[$];
  logic [66:0] exp_lsu_q[$];

  ysyx_210238_axi_rd_arb_if #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) bus ();

  ysyx_210238_axi_rd_arb #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus.m_ar_valid && bus.m_ar_ready) begin
      if (exp_ar_q.size() == 0) fail_evt("ar_unexpected");
      else chk("ar_payload", {bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len, bus.m_ar_size},
               exp_ar_q.pop_front());
    end
    if (bus.if_rsp_valid && bus.if_rsp_ready) begin
      if (exp_if_q.size() == 0) fail_evt("if_rsp_unexpected");
      else chk("if_rsp_beat", {bus.if_rsp_data, bus.if_rsp_resp, bus.if_rsp_last},
               exp_if_q.pop_front());
    end
    if (bus.lsu_rsp_valid && bus.lsu_rsp_ready) begin
      if (exp_lsu_q.size() == 0) fail_evt("lsu_rsp_unexpected");
      else chk("lsu_rsp_beat", {bus.lsu_rsp_data, bus.lsu_rsp_resp, bus.lsu_rsp_last},
               exp_lsu_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic push_ar(input bit lsu, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    exp_ar_q.push_back({lsu ? ID_LSU : ID_IF, addr, len, size});
  endtask

  // Requester: raise valid, hold until ready is seen, report cycles waited.
  task automatic req_drive(input bit lsu, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, output int waited);
    bit done = 1'b0;
    waited = 0;
    if (lsu) begin
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = addr;
      bus.lsu_req_len = len;    bus.lsu_req_size = size;
    end else begin
      bus.if_req_valid = 1'b1;  bus.if_req_addr = addr;
      bus.if_req_len = len;     bus.if_req_size = size;
    end
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (lsu ? bus.lsu_req_ready : bus.if_req_ready) done = 1'b1;
      else waited++;
      @(posedge clk); #1;
    end
    if (lsu) bus.lsu_req_valid = 1'b0;
    else     bus.if_req_valid  = 1'b0;
    if (!done) fail_evt(lsu ? "lsu_req_timeout" : "if_req_timeout");
  endtask

  // AXI bridge model: accept one AR (after ar_stall cycles), return len+1
  // beats. abort_after >= 0 leaves that beat on the bus and returns early.
  task automatic serve(input bit lsu, input int ar_stall, input int len,
                       input logic [1:0] resp, input int abort_after);
    bit seen = 1'b0;
    bit got;
    logic [63:0] data;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_ar_valid) seen = 1'b1;
    end
    if (!seen) begin
      fail_evt("ar_valid_timeout");
      return;
    end
    for (int k = 0; k < ar_stall; k++) begin
      chk("ar_stall_valid", bus.m_ar_valid, 1'b1);
      if (exp_ar_q.size() != 0)
        chk("ar_stall_payload", {bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len, bus.m_ar_size},
            exp_ar_q[0]);
      chk("ar_stall_req_ready", {bus.if_req_ready, bus.lsu_req_ready}, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.m_ar_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ar_ready = 1'b0;
    for (int b = 0; b <= len; b++) begin
      data = 64'hDA7A_0000_0000_0000 | 64'(beat_seq);
      beat_seq++;
      bus.m_r_valid = 1'b1;
      bus.m_r_data  = data;
      bus.m_r_resp  = resp;
      bus.m_r_last  = (b == len);
      if (b == abort_after) return;
      if (lsu) exp_lsu_q.push_back({data, resp, (b == len)});
      else     exp_if_q.push_back({data, resp, (b == len)});
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (bus.m_r_ready) begin
          got = 1'b1;
          chk("other_rsp_valid", lsu ? bus.if_rsp_valid : bus.lsu_rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
      end
      if (!got) fail_evt("r_handshake_timeout");
    end
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    chk("busy_after_last", busy, 1'b0);
    chk("state_after_last", state_o, ST_IDLE);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.if_req_valid = 0;  bus.if_req_addr = '0;  bus.if_req_len = '0;  bus.if_req_size = '0;
    bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_len = '0; bus.lsu_req_size = '0;
    bus.if_rsp_ready = 0;  bus.lsu_rsp_ready = 0;
    bus.m_ar_ready = 0;    bus.m_r_valid = 0;     bus.m_r_data = '0;
    bus.m_r_resp = '0;     bus.m_r_last = 0;
    rst_n = 1'b0;

    // Reset values, including ready held low despite a pending request.
    repeat (3) @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    #1;
    chk("rst_if_req_ready", bus.if_req_ready, 1'b0);
    chk("rst_m_ar_valid", bus.m_ar_valid, 1'b0);
    chk("rst_m_ar_payload", {bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len, bus.m_ar_size}, '0);
    chk("rst_m_r_ready", bus.m_r_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_rsp_valid", {bus.if_rsp_valid, bus.lsu_rsp_valid}, 2'b00);
    bus.if_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.if_rsp_ready  = 1'b1;
    bus.lsu_rsp_ready = 1'b1;

    // T1: IF only, 4-beat burst.
    push_ar(0, 64'h8000_0000, 8'd3, 3'd3);
    req_drive(0, 64'h8000_0000, 8'd3, 3'd3, w_if);
    chk("t1_ready_latency", w_if, 0);
    chk("t1_ar_valid_next", bus.m_ar_valid, 1'b1);
    chk("t1_busy", busy, 1'b1);
    serve(0, 0, 3, RESP_OKAY, -1);

    // T2: tie from reset -> IF first, then LSU with its own address.
    do_reset();
    push_ar(0, 64'h8000_0100, 8'd1, 3'd3);
    push_ar(1, 64'h1000_0040, 8'd1, 3'd2);
    fork
      req_drive(0, 64'h8000_0100, 8'd1, 3'd3, w_if);
      req_drive(1, 64'h1000_0040, 8'd1, 3'd2, w_lsu);
      begin
        serve(0, 0, 1, RESP_OKAY, -1);
        serve(1, 0, 1, RESP_OKAY, -1);
      end
    join
    chk("t2_if_wait", w_if, 0);
    chk("t2_lsu_waited", (w_lsu > 0), 1'b1);

    // T3: three consecutive ties alternate IF, LSU, IF (then LSU alone).
    push_ar(0, 64'h8000_1000, 8'd0, 3'd3);
    push_ar(1, 64'h2000_0000, 8'd0, 3'd3);
    push_ar(0, 64'h8000_2000, 8'd2, 3'd3);
    push_ar(1, 64'h2000_0008, 8'd0, 3'd1);
    fork
      begin
        req_drive(0, 64'h8000_1000, 8'd0, 3'd3, w_tmp);
        req_drive(0, 64'h8000_2000, 8'd2, 3'd3, w_tmp);
      end
      begin
        req_drive(1, 64'h2000_0000, 8'd0, 3'd3, w_tmp);
        req_drive(1, 64'h2000_0008, 8'd0, 3'd1, w_tmp);
      end
      begin
        serve(0, 0, 0, RESP_OKAY, -1);
        serve(1, 0, 0, RESP_OKAY, -1);
        serve(0, 0, 2, RESP_OKAY, -1);
        serve(1, 0, 0, RESP_OKAY, -1);
      end
    join

    // T4: AR backpressure while IF already holds its next request.
    push_ar(0, 64'h8000_3000, 8'd0, 3'd3);
    push_ar(0, 64'h8000_3040, 8'd0, 3'd3);
    fork
      begin
        req_drive(0, 64'h8000_3000, 8'd0, 3'd3, w_tmp);
        req_drive(0, 64'h8000_3040, 8'd0, 3'd3, w_if);
      end
      begin
        serve(0, 5, 0, RESP_OKAY, -1);
        serve(0, 0, 0, RESP_OKAY, -1);
      end
    join
    chk("t4_second_req_waited", (w_if >= 5), 1'b1);

    // T5: LSU single beat with SLVERR and response backpressure.
    bus.lsu_rsp_ready = 1'b0;
    push_ar(1, 64'h3000_0010, 8'd0, 3'd3);
    fork
      req_drive(1, 64'h3000_0010, 8'd0, 3'd3, w_tmp);
      serve(1, 0, 0, RESP_SLVERR, -1);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (bus.lsu_rsp_valid) seen = 1'b1;
        end
        if (!seen) fail_evt("t5_rsp_valid_timeout");
        for (int k = 0; k < 3; k++) begin
          chk("t5_m_r_ready_low", bus.m_r_ready, 1'b0);
          chk("t5_resp", bus.lsu_rsp_resp, RESP_SLVERR);
          chk("t5_last", bus.lsu_rsp_last, 1'b1);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.lsu_rsp_ready = 1'b1;
        #1;
        chk("t5_m_r_ready_follows", bus.m_r_ready, 1'b1);
      end
    join

    // T6: asynchronous reset in the middle of an 8-beat IF burst.
    push_ar(0, 64'h8000_4000, 8'd7, 3'd3);
    fork
      req_drive(0, 64'h8000_4000, 8'd7, 3'd3, w_tmp);
      serve(0, 0, 7, RESP_OKAY, 2);
    join
    chk("t6_mid_burst_valid", bus.if_rsp_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
    chk("t6_rst_if_rsp_data", bus.if_rsp_data, 64'h0);
    chk("t6_rst_m_r_ready", bus.m_r_ready, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_state", state_o, ST_IDLE);
    chk("t6_rst_ar", {bus.m_ar_valid, bus.m_ar_addr}, '0);
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_ar(0, 64'h8000_5000, 8'd0, 3'd3);
    push_ar(1, 64'h4000_0000, 8'd0, 3'd3);
    fork
      req_drive(0, 64'h8000_5000, 8'd0, 3'd3, w_if);
      req_drive(1, 64'h4000_0000, 8'd0, 3'd3, w_tmp);
      begin
        serve(0, 0, 0, RESP_OKAY, -1);
        serve(1, 0, 0, RESP_OKAY, -1);
      end
    join
    chk("t6_if_wins_tie", w_if, 0);

    // Everything queued must have been observed.
    repeat (2) @(posedge clk);
    chk("end_ar_q_empty", exp_ar_q.size(), 0);
    chk("end_if_q_empty", exp_if_q.size(), 0);
    chk("end_lsu_q_empty", exp_lsu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
